// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver.
// Deserialises one frame (start bit 0, dataLen data bits LSB first,
// optional XOR parity bit, 1 or 2 stop bits) into a parallel word, and
// delivers it with a one-cycle strobe and per-frame error flags.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   dataIn    in   serial line, asynchronous to clk, idles high
//   data      out  last received word, held until the next frame completes
//   valid     out  one-cycle strobe: data/parErr/frameErr updated this cycle
//   parErr    out  parity mismatch on the strobed frame (0 when par=0)
//   frameErr  out  a stop bit of the strobed frame was sampled as 0
//   busy      out  1 while a frame is in progress (state other than IDLE)
module uart_rx #(
   parameter int unsigned T        = 9600,
   parameter int unsigned par      = 0,
   parameter int unsigned parType  = 0,
   parameter int unsigned stop     = 1,
   parameter int unsigned dataLen  = 8,
   parameter int unsigned F_clk_Gz = 100_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               dataIn,
   output logic [dataLen-1:0] data,
   output logic               valid,
   output logic               parErr,
   output logic               frameErr,
   output logic               busy
);

   // Clocks per bit and derived counter widths.
   localparam int unsigned PERIOD = F_clk_Gz / T;
   localparam int unsigned TMR_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned CNT_W  = $clog2(dataLen + 1);

   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(PERIOD - 1);
   localparam logic [TMR_W-1:0] TMR_HALF  = TMR_W'(PERIOD / 2 - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(dataLen - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(stop - 1);

   // Parity bit is consumed whenever present; only the XOR type is checked,
   // reserved types never raise parErr.
   localparam bit PAR_EN  = (par != 0);
   localparam bit PAR_CHK = PAR_EN && (parType == 0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [1:0]         sync_q,   sync_d;
   logic [2:0]         state_q,  state_d;
   logic [TMR_W-1:0]   timer_q,  timer_d;
   logic [CNT_W-1:0]   bcnt_q,   bcnt_d;
   logic [dataLen-1:0] shift_q,  shift_d;
   logic               perr_q,   perr_d;
   logic               ferr_q,   ferr_d;
   logic               armed_q,  armed_d;
   logic [dataLen-1:0] data_q,   data_d;
   logic               valid_q,  valid_d;
   logic               par_err_q,   par_err_d;
   logic               frame_err_q, frame_err_d;
   logic               busy_q,   busy_d;

   logic rxs;
   logic tick_last;
   logic tick_half;

   // Synchronised line; every decision below uses only this.
   assign rxs       = sync_q[1];
   assign tick_last = (timer_q == TMR_LAST);
   assign tick_half = (timer_q == TMR_HALF);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= '1;
         state_q     <= S_IDLE;
         timer_q     <= '0;
         bcnt_q      <= '0;
         shift_q     <= '0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         armed_q     <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         timer_q     <= timer_d;
         bcnt_q      <= bcnt_d;
         shift_q     <= shift_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         armed_q     <= armed_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         par_err_q   <= par_err_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      sync_d      = {sync_q[0], dataIn};
      state_d     = state_q;
      timer_d     = tick_last ? '0 : timer_q + TMR_W'(1);
      bcnt_d      = bcnt_q;
      shift_d     = shift_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      armed_d     = armed_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      par_err_d   = par_err_q;
      frame_err_d = frame_err_q;

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            bcnt_d  = '0;
            // Only a high-to-low transition starts a frame, so a held-low
            // line (break) cannot retrigger.
            if (rxs) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = S_START;
               armed_d = 1'b0;
            end
         end

         S_START: begin
            if (tick_half) begin
               timer_d = '0;
               if (!rxs) begin
                  state_d = S_DATA;
                  bcnt_d  = '0;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
               end else begin
                  // Line back high at mid start bit: glitch, drop silently.
                  state_d = S_IDLE;
               end
            end
         end

         S_DATA: begin
            if (tick_last) begin
               // Shifting in from the top places bit k at position k once
               // all dataLen bits have arrived.
               shift_d = {rxs, shift_q[dataLen-1:1]};
               if (bcnt_q == DATA_LAST) begin
                  bcnt_d  = '0;
                  state_d = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  bcnt_d = bcnt_q + CNT_W'(1);
               end
            end
         end

         S_PARITY: begin
            if (tick_last) begin
               perr_d  = PAR_CHK && (rxs != ^shift_q);
               state_d = S_STOP;
            end
         end

         S_STOP: begin
            if (tick_last) begin
               if (!rxs) begin
                  ferr_d = 1'b1;
               end
               if (bcnt_q == STOP_LAST) begin
                  // Back to IDLE at mid stop bit; a good final stop bit
                  // re-arms at once so an immediate next start is caught.
                  state_d     = S_IDLE;
                  armed_d     = rxs;
                  valid_d     = 1'b1;
                  data_d      = shift_q;
                  par_err_d   = perr_q;
                  frame_err_d = ferr_q | ~rxs;
               end else begin
                  bcnt_d = bcnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign data     = data_q;
   assign valid    = valid_q;
   assign parErr   = par_err_q;
   assign frameErr = frame_err_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx.
// Three receivers share one clock at 10 clocks per bit:
//   dut 0: no parity, 1 stop bit
//   dut 1: XOR parity, 1 stop bit
//   dut 2: no parity, 2 stop bits
// The driver builds frames bit by bit in time units; the expected word and
// flags of each frame are computed from the bits actually sent.
module tb_uart_rx;

   localparam int CLK_PERIOD = 10;
   localparam int CLK_HALF   = 5;
   localparam int BIT_NOM    = 100;

   logic clk = 1'b0;
   always #(CLK_HALF) clk = ~clk;

   logic rst, rst0;
   logic line0, line1, line2;

   logic [7:0] d0, d1, d2;
   logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, b0, b1, b2;

   uart_rx #(.T(100_000), .par(0), .parType(0), .stop(1), .dataLen(8), .F_clk_Gz(1_000_000)) u_dut0 (
      .clk(clk), .rst(rst0), .dataIn(line0), .data(d0), .valid(v0),
      .parErr(pe0), .frameErr(fe0), .busy(b0));

   uart_rx #(.T(100_000), .par(1), .parType(0), .stop(1), .dataLen(8), .F_clk_Gz(1_000_000)) u_dut1 (
      .clk(clk), .rst(rst), .dataIn(line1), .data(d1), .valid(v1),
      .parErr(pe1), .frameErr(fe1), .busy(b1));

   uart_rx #(.T(100_000), .par(0), .parType(0), .stop(2), .dataLen(8), .F_clk_Gz(1_000_000)) u_dut2 (
      .clk(clk), .rst(rst), .dataIn(line2), .data(d2), .valid(v2),
      .parErr(pe2), .frameErr(fe2), .busy(b2));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Frame records: {dut index[1:0], parErr, frameErr, data[7:0]}
   logic [11:0] obs_q[$];
   logic [11:0] exp_q[$];
   int  vcnt0 = 0, vcnt1 = 0, vcnt2 = 0, bcnt0 = 0;
   time t_valid0 = 0;
   time t_fall0  = 0;

   // Output monitor, sampled away from the rising edge.
   always @(negedge clk) begin
      if (v0) begin
         obs_q.push_back({2'd0, pe0, fe0, d0});
         vcnt0++;
         t_valid0 = $time;
      end
      if (v1) begin
         obs_q.push_back({2'd1, pe1, fe1, d1});
         vcnt1++;
      end
      if (v2) begin
         obs_q.push_back({2'd2, pe2, fe2, d2});
         vcnt2++;
      end
      if (b0) bcnt0++;
   end

   task automatic drive(input int idx, input logic v);
      case (idx)
         0:       line0 = v;
         1:       line1 = v;
         default: line2 = v;
      endcase
   endtask

   // Send one frame shaped for dut idx and record the expected result.
   task automatic send_frame(input int idx, input logic [7:0] d, input logic pbit,
                             input logic s1, input logic s2, input int bit_ns);
      bit   has_par = (idx == 1);
      int   nstop   = (idx == 2) ? 2 : 1;
      logic perr, ferr;
      drive(idx, 1'b0);
      if (idx == 0) t_fall0 = $time;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         drive(idx, d[i]);
         #(bit_ns);
      end
      if (has_par) begin
         drive(idx, pbit);
         #(bit_ns);
      end
      drive(idx, s1);
      #(bit_ns);
      if (nstop == 2) begin
         drive(idx, s2);
         #(bit_ns);
      end
      perr = has_par && (pbit != ^d);
      ferr = !s1 || ((nstop == 2) && !s2);
      exp_q.push_back({2'(idx), perr, ferr, d});
   endtask

   task automatic idle(input int idx, input int bits, input int bit_ns);
      drive(idx, 1'b1);
      #(bits * bit_ns);
   endtask

   // Let the last strobe land, then compare observed frames against the model.
   task automatic score(input string tag);
      repeat (40) @(negedge clk);
      check({tag, "_frames"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0)
         check({tag, "_frame"}, obs_q.pop_front(), exp_q.pop_front());
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int         lat, vb, bb, bit_ns, gap, idx;
      logic [7:0] d;
      logic       pbit, s1, s2;
      int         skew[3] = '{100, 97, 103};
      logic [7:0] b2b[3]  = '{8'h00, 8'hFF, 8'h81};

      line0 = 1'b1; line1 = 1'b1; line2 = 1'b1;
      rst = 1'b1; rst0 = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_dut0", {d0, v0, pe0, fe0, b0}, 12'h0);
      check("reset_dut2", {d2, v2, pe2, fe2, b2}, 12'h0);
      rst = 1'b0; rst0 = 1'b0;
      repeat (10) @(negedge clk);
      #3;

      // Basic frame and strobe latency (rising edges from line edge to strobe).
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, BIT_NOM);
      idle(0, 2, BIT_NOM);
      lat = int'((t_valid0 - t_fall0 + CLK_HALF) / CLK_PERIOD);
      check("t1_latency_clks", lat, 98);
      score("t1");

      // Parity good and forced bad.
      send_frame(1, 8'h03, 1'b0, 1'b1, 1'b1, BIT_NOM);
      idle(1, 2, BIT_NOM);
      send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, BIT_NOM);
      idle(1, 2, BIT_NOM);
      score("t2");

      // Second stop bit low, then line held low (break).
      vb = vcnt2;
      send_frame(2, 8'h5A, 1'b0, 1'b1, 1'b0, BIT_NOM);
      #(30 * BIT_NOM);
      check("t3_break_single_frame", vcnt2 - vb, 1);
      idle(2, 3, BIT_NOM);
      send_frame(2, 8'h11, 1'b0, 1'b1, 1'b1, BIT_NOM);
      idle(2, 2, BIT_NOM);
      score("t3");

      // Short glitch: busy pulses, nothing delivered, word held.
      vb = vcnt0;
      bb = bcnt0;
      drive(0, 1'b0);
      #(3 * CLK_PERIOD);
      drive(0, 1'b1);
      repeat (30) @(negedge clk);
      check("t4_busy_seen", bcnt0 > bb, 1);
      check("t4_busy_clear", b0, 0);
      check("t4_no_valid", vcnt0 - vb, 0);
      check("t4_data_held", d0, 8'hA5);
      #3;

      // Back-to-back frames at nominal and +-3% driver rate.
      foreach (skew[k]) begin
         foreach (b2b[j]) send_frame(0, b2b[j], 1'b0, 1'b1, 1'b1, skew[k]);
         idle(0, 2, skew[k]);
         score($sformatf("t5_b2b_%0d", skew[k]));
      end

      // Randomized frames across all three receivers.
      for (int n = 0; n < 30; n++) begin
         idx    = $urandom_range(0, 2);
         d      = 8'($urandom);
         pbit   = (^d) ^ ($urandom_range(0, 3) == 0);
         s1     = ($urandom_range(0, 4) != 0);
         s2     = ($urandom_range(0, 4) != 0);
         bit_ns = skew[$urandom_range(0, 2)];
         send_frame(idx, d, pbit, s1, s2, bit_ns);
         gap = $urandom_range(0, 2);
         // A low final stop bit leaves the receiver disarmed until high.
         if (((idx == 2) ? s2 : s1) == 1'b0 && gap == 0) gap = 1;
         if (gap > 0) idle(idx, gap, bit_ns);
      end
      idle(0, 2, BIT_NOM);
      score("rand");

      // Reset during data bit 4 of 0x3C; sender also abandons the frame.
      vb = vcnt0;
      d  = 8'h3C;
      drive(0, 1'b0);
      #(BIT_NOM);
      for (int i = 0; i < 5; i++) begin
         drive(0, d[i]);
         if (i < 4) #(BIT_NOM);
      end
      #(BIT_NOM / 2);
      @(negedge clk) rst0 = 1'b1;
      @(negedge clk) rst0 = 1'b0;
      check("t6_reset_outputs", {d0, v0, pe0, fe0, b0}, 12'h0);
      drive(0, 1'b1);
      repeat (300) @(negedge clk);
      check("t6_no_partial_valid", vcnt0 - vb, 0);
      check("t6_data_cleared", d0, 8'h00);
      #3;
      send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1, BIT_NOM);
      idle(0, 2, BIT_NOM);
      score("t6");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
